// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared macros, register map and pending-update helper for int_ctrl
`ifndef INT_CTRL_DEFINES
`define INT_CTRL_DEFINES
`define RstEnable       1'b1
`define WriteEnable     1'b1
`define ZeroWord        32'h0000_0000
`define InterruptAssert 1'b1
`define IntCtrlPend     2'd0
`define IntCtrlMask     2'd1
`define IntCtrlMode     2'd2
`define IntCtrlRaw      2'd3
`define IntBus          5:0
`endif

package int_ctrl_pkg;

   localparam int INT_W = 6;

   typedef enum logic [1:0] {
      REG_PEND = `IntCtrlPend,
      REG_MASK = `IntCtrlMask,
      REG_MODE = `IntCtrlMode,
      REG_RAW  = `IntCtrlRaw
   } int_reg_e;

   // Mode change clears first, then edge lines latch (set beats W1C), level lines track.
   function automatic logic [`IntBus] next_pending(
      input logic [`IntBus] pend,
      input logic [`IntBus] mode,
      input logic [`IntBus] level,
      input logic [`IntBus] rise,
      input logic [`IntBus] clr,
      input logic [`IntBus] mode_chg
   );
      logic [`IntBus] nxt;
      nxt = '0;
      for (int i = 0; i < INT_W; i++) begin
         if (mode_chg[i])
            nxt[i] = 1'b0;
         else if (mode[i])
            nxt[i] = rise[i] | (pend[i] & ~clr[i]);
         else
            nxt[i] = level[i];
      end
      return nxt;
   endfunction

endpackage

// File: rtl/int_ctrl_sync_chain.sv
// rtl/int_ctrl_sync_chain.sv - SYNC_STAGES-deep single-bit synchroniser with synchronous reset
module int_ctrl_sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sh;

   always_ff @(posedge clk) begin
      if (rst_n == `RstEnable)
         sh <= '0;
      else
         sh <= {sh[SYNC_STAGES-2:0], d};
   end

   assign q = sh[SYNC_STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt front-end: sync, level/edge pending, mask, CP0 IP[7:2] vector
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [5:0] RESET_MASK  = 6'b111111,
   parameter logic [5:0] RESET_MODE  = 6'b000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  irq_i,
   input  logic        timer_int_i,
   input  logic        we_i,
   input  logic [1:0]  waddr_i,
   input  logic [1:0]  raddr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic [5:0]  int_o
);

   logic [`IntBus] s;
   logic [`IntBus] l;
   logic [`IntBus] p;
   logic [`IntBus] e;
   logic [`IntBus] pend;
   logic [`IntBus] mask;
   logic [`IntBus] mode;
   logic [`IntBus] clr;
   logic [`IntBus] mode_chg;
   logic           wr_pend;
   logic           wr_mask;
   logic           wr_mode;
   logic           unused_data_hi;

   for (genvar i = 0; i < INT_W; i++) begin : g_sync
      int_ctrl_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst_n(rst_n),
         .d    (irq_i[i]),
         .q    (s[i])
      );
   end

   // Timer is already in the clk domain, so it joins line 5 after the synchroniser.
   assign l = {s[5] | timer_int_i, s[4:0]};
   assign e = l & ~p;

   assign wr_pend  = (we_i == `WriteEnable) && (waddr_i == REG_PEND);
   assign wr_mask  = (we_i == `WriteEnable) && (waddr_i == REG_MASK);
   assign wr_mode  = (we_i == `WriteEnable) && (waddr_i == REG_MODE);
   assign clr      = wr_pend ? data_i[`IntBus] : '0;
   assign mode_chg = wr_mode ? (data_i[`IntBus] ^ mode) : '0;

   assign unused_data_hi = ^data_i[31:6];

   always_ff @(posedge clk) begin
      if (rst_n == `RstEnable) begin
         p     <= '0;
         pend  <= '0;
         mask  <= RESET_MASK;
         mode  <= RESET_MODE;
         int_o <= '0;
      end else begin
         p     <= l;
         pend  <= next_pending(pend, mode, l, e, clr, mode_chg);
         int_o <= pend & mask;
         if (wr_mask)
            mask <= data_i[`IntBus];
         if (wr_mode)
            mode <= data_i[`IntBus];
      end
   end

   always_comb begin
      data_o = `ZeroWord;
      if (rst_n != `RstEnable) begin
         case (raddr_i)
            REG_PEND: data_o = {26'b0, pend};
            REG_MASK: data_o = {26'b0, mask};
            REG_MODE: data_o = {26'b0, mode};
            default:  data_o = {26'b0, l};
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  irq_i;
   logic        timer_int_i;
   logic        we_i;
   logic [1:0]  waddr_i;
   logic [1:0]  raddr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [5:0]  int_o;

   int checks = 0;
   int errors = 0;

   int_ctrl #(.SYNC_STAGES(2), .RESET_MASK(6'h3F), .RESET_MODE(6'h00)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_i      (irq_i),
      .timer_int_i(timer_int_i),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .raddr_i    (raddr_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .int_o      (int_o)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; data_i = d;
      step(1);
      we_i = 1'b0; data_i = 32'h0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      raddr_i = a;
      #1 d = data_o;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst_n = 1'b1; irq_i = 6'h3F;
      step(3);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL reset_int_o got %h exp %h", int_o, 6'h00); end
      rd(2'd1, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_data_o got %h exp %h", d, 32'h0); end
      rst_n = 1'b0;
      rd(2'd1, d);
      checks++;
      if (d !== 32'h3F) begin errors++; $display("FAIL reset_mask got %h exp %h", d, 32'h3F); end
      rd(2'd2, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_mode got %h exp %h", d, 32'h0); end
      step(2);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL release_early got %h exp %h", int_o, 6'h00); end
      step(2);
      checks++;
      if (int_o !== 6'h3F) begin errors++; $display("FAIL release_level got %h exp %h", int_o, 6'h3F); end
      irq_i = 6'h00;
      step(5);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL settle_idle got %h exp %h", int_o, 6'h00); end
   endtask

   task automatic test_edge_latch;
      wr(2'd2, 32'h01);
      irq_i = 6'h01;
      step(2);
      irq_i = 6'h00;
      step(1);
      checks++;
      if (int_o[0] !== 1'b0) begin errors++; $display("FAIL edge_early got %b exp %b", int_o[0], 1'b0); end
      step(1);
      checks++;
      if (int_o[0] !== 1'b1) begin errors++; $display("FAIL edge_rise got %b exp %b", int_o[0], 1'b1); end
      step(4);
      checks++;
      if (int_o !== 6'h01) begin errors++; $display("FAIL edge_held got %h exp %h", int_o, 6'h01); end
      wr(2'd0, 32'h1);
      checks++;
      if (int_o[0] !== 1'b1) begin errors++; $display("FAIL w1c_lag got %b exp %b", int_o[0], 1'b1); end
      step(1);
      checks++;
      if (int_o[0] !== 1'b0) begin errors++; $display("FAIL w1c_clear got %b exp %b", int_o[0], 1'b0); end
   endtask

   task automatic test_set_beats_clear;
      logic [31:0] d;
      wr(2'd2, 32'h03);
      irq_i = 6'h02;
      step(2);
      wr(2'd0, 32'h2);
      rd(2'd0, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL set_wins_pend got %h exp %h", d, 32'h2); end
      step(1);
      checks++;
      if (int_o !== 6'h02) begin errors++; $display("FAIL set_wins_int got %h exp %h", int_o, 6'h02); end
      irq_i = 6'h00;
      wr(2'd0, 32'h2);
      step(1);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL set_wins_cleanup got %h exp %h", int_o, 6'h00); end
   endtask

   task automatic test_level_mask;
      logic [31:0] d;
      wr(2'd2, 32'h00);
      irq_i = 6'h08;
      step(5);
      checks++;
      if (int_o !== 6'h08) begin errors++; $display("FAIL level_high got %h exp %h", int_o, 6'h08); end
      wr(2'd1, 32'h37);
      checks++;
      if (int_o !== 6'h08) begin errors++; $display("FAIL mask_lag got %h exp %h", int_o, 6'h08); end
      step(1);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL mask_drop got %h exp %h", int_o, 6'h00); end
      rd(2'd0, d);
      checks++;
      if (d !== 32'h08) begin errors++; $display("FAIL mask_pend got %h exp %h", d, 32'h08); end
      wr(2'd0, 32'h08);
      rd(2'd0, d);
      checks++;
      if (d !== 32'h08) begin errors++; $display("FAIL level_w1c got %h exp %h", d, 32'h08); end
      wr(2'd1, 32'h3F);
      irq_i = 6'h00;
      step(5);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL level_release got %h exp %h", int_o, 6'h00); end
   endtask

   task automatic test_timer;
      logic [31:0] d;
      wr(2'd2, 32'h20);
      timer_int_i = 1'b1;
      rd(2'd3, d);
      checks++;
      if (d !== 32'h20) begin errors++; $display("FAIL timer_raw got %h exp %h", d, 32'h20); end
      step(1);
      timer_int_i = 1'b0;
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL timer_e0 got %h exp %h", int_o, 6'h00); end
      step(1);
      checks++;
      if (int_o !== 6'h20) begin errors++; $display("FAIL timer_e1 got %h exp %h", int_o, 6'h20); end
      step(3);
      checks++;
      if (int_o !== 6'h20) begin errors++; $display("FAIL timer_held got %h exp %h", int_o, 6'h20); end
      wr(2'd0, 32'h20);
      step(1);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL timer_clear got %h exp %h", int_o, 6'h00); end
   endtask

   task automatic test_mode_switch;
      logic [31:0] d;
      wr(2'd2, 32'h04);
      irq_i = 6'h04;
      step(2);
      irq_i = 6'h00;
      step(4);
      rd(2'd0, d);
      checks++;
      if (d !== 32'h04) begin errors++; $display("FAIL mode_pend_set got %h exp %h", d, 32'h04); end
      checks++;
      if (int_o !== 6'h04) begin errors++; $display("FAIL mode_int_set got %h exp %h", int_o, 6'h04); end
      wr(2'd2, 32'h00);
      rd(2'd0, d);
      checks++;
      if (d !== 32'h00) begin errors++; $display("FAIL mode_pend_clr got %h exp %h", d, 32'h00); end
      step(1);
      checks++;
      if (int_o !== 6'h00) begin errors++; $display("FAIL mode_int_clr got %h exp %h", int_o, 6'h00); end
   endtask

   initial begin
      rst_n = 1'b1; irq_i = 6'h00; timer_int_i = 1'b0;
      we_i = 1'b0; waddr_i = 2'd0; raddr_i = 2'd0; data_i = 32'h0;
      @(negedge clk);
      test_reset;
      test_edge_latch;
      test_set_beats_clear;
      test_level_mask;
      test_timer;
      test_mode_switch;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt front-end that sits directly upstream of the CP0 register block.
- Synchronises the six external hardware interrupt lines and ORs the CP0 timer interrupt into line 5.
- Applies per-line level/edge mode and mask, latches pending edges, and drives the registered 6-bit vector into CP0 cause bits IP[7:2].
- Software clears edge-latched lines and configures mode/mask through a small register port on the data bus.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages per external line; legal values 2..3.
- RESET_MASK, 6'b111111, value loaded into MASK at reset.
- RESET_MODE, 6'b000000, value loaded into MODE at reset (1 = edge, 0 = level).

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  synchronous, active-high reset, asserted when rst_n == `RstEnable (`RstEnable = 1'b1).
- irq_i  in  6  asynchronous external interrupt lines.
- timer_int_i  in  1  CP0 timer interrupt, already in the clk domain.
- we_i  in  1  register write strobe.
- waddr_i  in  2  write address.
- raddr_i  in  2  read address.
- data_i  in  32  write data; only [5:0] is used.
- data_o  out  32  combinational read data.
- int_o  out  6  registered interrupt vector to CP0 int_i.

Behaviour:
- Register map:
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: read/write.
  - 2 MODE: read/write.
  - 3 RAW: read-only, returns synchronised line levels.
- Read data: data_o = {26'b0, reg[5:0]}; a RAW read includes the timer OR on bit 5. When reset is asserted, data_o = `ZeroWord.
- Reset values: int_o = 0, PENDING = 0, all synchroniser and previous-sample flops = 0, MASK = RESET_MASK, MODE = RESET_MODE.
- Synchroniser: each irq_i line passes through SYNC_STAGES flops to give s[i].
- Line 5 effective level: l[5] = s[5] | timer_int_i. timer_int_i is not synchronised. For lines 0..4, l[i] = s[i].
- Previous sample: p[i] <= l[i] every cycle. Rising edge: e[i] = l[i] & ~p[i].
- Level mode (MODE[i] = 0): PENDING[i] <= l[i] every cycle. W1C writes have no effect on level lines.
- Edge mode (MODE[i] = 1): PENDING[i] is set on e[i] and held until a W1C write with data_i[i] = 1.
- Same-cycle set and W1C clear on one line: set wins, so the line stays pending.
- Output: int_o <= PENDING & MASK, registered one cycle after PENDING.
- Latency, external line: irq_i stable high before clock edge E0 gives int_o high after edge E(SYNC_STAGES+1). That is 3 edges for SYNC_STAGES = 2 (synchroniser 2, pending 1, output 1, with the first synchroniser sample at E0).
- Latency, timer: timer_int_i high before E0 gives PENDING[5] at E0 and int_o[5] at E1.
- MODE write: every line whose mode bit changes has PENDING cleared in that cycle. This takes precedence over set and over level tracking. From the next cycle the line follows the new mode.
- MASK write: affects int_o on the following edge only. PENDING is unaffected, so unmasking a latched edge asserts int_o one cycle after the write.
- Writes to RAW are ignored. Only one write per cycle (single we_i).
- Reset mid-operation: all state returns to reset values in the same edge. Edges latched before reset are lost. A line still high after reset produces a fresh edge, because p = 0 after reset.
- Pulse shorter than one clk period: it may be missed. Capture is not guaranteed; this is documented, not a bug.

Decomposition:
- Shared macro header additions:
  - `IntCtrlPend = 2'd0, `IntCtrlMask = 2'd1, `IntCtrlMode = 2'd2, `IntCtrlRaw = 2'd3.
  - `IntBus = 5:0.
  - Reuse of `RstEnable, `WriteEnable, `ZeroWord, `InterruptAssert.
- One natural sub-module, sync_chain: a SYNC_STAGES-deep 1-bit synchroniser with synchronous active-high reset, instantiated five times (lines 0..4) plus once for line 5 before the timer OR.

Test Plan:
- Reset defaults: hold reset 3 cycles with irq_i = 6'h3F. Then int_o = 0, a MASK read returns 32'h3F, and a MODE read returns 0. Release reset: int_o = 6'h3F at the third edge after release.
- Edge latch: write MODE = 6'h01, then pulse irq_i[0] for 2 cycles. int_o[0] rises 3 edges after the pulse and stays 1 after irq_i drops. Write PENDING = 32'h1: int_o[0] = 0 one edge after the W1C update.
- Set beats clear: in edge mode on line 1, time a W1C of bit 1 for the same cycle as a new rising edge. PENDING[1] stays 1 and int_o[1] stays 1.
- Level and mask: MODE = 0, irq_i[3] held high, then write MASK = 6'h37. int_o[3] drops one edge after the write; PENDING read = 32'h08. A W1C of 32'h08 leaves PENDING = 32'h08.
- Timer path: pulse timer_int_i for 1 cycle with irq_i = 0 and MODE[5] = 1. int_o[5] = 1 one edge after PENDING[5] sets (at E1) and stays latched; a RAW read during the pulse returns 32'h20.
- Mode switch clears: set line 2 pending in edge mode, then write MODE = 0 while irq_i[2] = 0. PENDING[2] = 0 and int_o[2] = 0 one edge later.
